// File: rtl/adder_6b_pkg.sv
// Shared constants for the 6-bit adder slice.
package adder_6b_pkg;

    localparam int          ADDER_WIDTH = 6;
    localparam logic [5:0]  ADDER_MASK  = 6'h3F;

endpackage : adder_6b_pkg

// File: rtl/adder_6b_full_adder.sv
// One-bit full adder cell used as a link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder_6b.sv
// Ripple-carry adder with combinational sum/carry/overflow and a one-cycle registered copy.
module adder_6b
    import adder_6b_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .co  (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
    // Signed overflow occurs exactly when the carry into the MSB differs from the carry out.
    assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    assign sum_d  = sum;
    assign cout_d = cout;
    assign ovf_d  = ovf;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so simulation order cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule : adder_6b

// File: tb/tb_adder_6b.sv
// Directed and exhaustive self-checking bench for adder_6b.
`timescale 1ns/1ps
module tb_adder_6b;
    import adder_6b_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] sum;
    logic       cout;
    logic       ovf;
    logic [5:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    int n_checks = 0;
    int n_fails  = 0;

    adder_6b dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        a     = 6'h00;
        b     = 6'h00;
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_regs: got sum_q=%h cout_q=%b ovf_q=%b, want 00 0 0", sum_q, cout_q, ovf_q);
        end
        n_checks++;
        if ({sum, cout, ovf} !== 8'h00) begin
            n_fails++;
            $display("FAIL zero_plus_zero: got sum=%h cout=%b ovf=%b, want 00 0 0", sum, cout, ovf);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sum_q !== 6'h00) begin
            n_fails++;
            $display("FAIL reset_held: got sum_q=%h, want 00", sum_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] exp7;
        for (int i = 0; i < 16; i++) begin
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            #10;
            exp7 = {1'b0, a} + {1'b0, b};
            n_checks++;
            if (sum !== (exp7[5:0] & ADDER_MASK)) begin
                n_fails++;
                $display("FAIL rand_sum: a=%h b=%h got sum=%h, want %h", a, b, sum, exp7[5:0]);
            end
        end
    endtask

    task automatic test_wrap();
        a = 6'h3F; b = 6'h01;
        #1;
        n_checks++;
        if ({sum, cout, ovf} !== {6'h00, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL wrap_3f_01: got sum=%h cout=%b ovf=%b, want 00 1 0", sum, cout, ovf);
        end
        a = 6'h3F; b = 6'h3F;
        #1;
        n_checks++;
        if ({sum, cout, ovf} !== {6'h3E, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL wrap_3f_3f: got sum=%h cout=%b ovf=%b, want 3e 1 0", sum, cout, ovf);
        end
    endtask

    task automatic test_signed_overflow();
        a = 6'h1F; b = 6'h01;
        #1;
        n_checks++;
        if ({sum, cout, ovf} !== {6'h20, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL ovf_1f_01: got sum=%h cout=%b ovf=%b, want 20 0 1", sum, cout, ovf);
        end
        a = 6'h20; b = 6'h20;
        #1;
        n_checks++;
        if ({sum, cout, ovf} !== {6'h00, 1'b1, 1'b1}) begin
            n_fails++;
            $display("FAIL ovf_20_20: got sum=%h cout=%b ovf=%b, want 00 1 1", sum, cout, ovf);
        end
    endtask

    task automatic test_pipeline();
        @(negedge clk);
        a = 6'h00; b = 6'h00;
        @(posedge clk);
        @(negedge clk);
        a = 6'h05; b = 6'h0A;
        #1;
        n_checks++;
        if (sum !== 6'h0F) begin
            n_fails++;
            $display("FAIL pipe_comb: got sum=%h, want 0f", sum);
        end
        n_checks++;
        if (sum_q !== 6'h00) begin
            n_fails++;
            $display("FAIL pipe_latency: sum_q=%h before edge, want 00", sum_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== {6'h0F, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL pipe_reg: got sum_q=%h cout_q=%b ovf_q=%b, want 0f 0 0", sum_q, cout_q, ovf_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 6'h3F; b = 6'h3F;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== {6'h3E, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL areset_pre: got sum_q=%h cout_q=%b ovf_q=%b, want 3e 1 0", sum_q, cout_q, ovf_q);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== 8'h00) begin
            n_fails++;
            $display("FAIL areset_clear: got sum_q=%h cout_q=%b ovf_q=%b, want 00 0 0", sum_q, cout_q, ovf_q);
        end
        n_checks++;
        if ({sum, cout} !== {6'h3E, 1'b1}) begin
            n_fails++;
            $display("FAIL areset_comb: got sum=%h cout=%b, want 3e 1", sum, cout);
        end
        a = 6'h1F; b = 6'h01;
        #1;
        n_checks++;
        if ({sum, ovf, ovf_q} !== {6'h20, 1'b1, 1'b0}) begin
            n_fails++;
            $display("FAIL areset_track: got sum=%h ovf=%b ovf_q=%b, want 20 1 0", sum, ovf, ovf_q);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== 8'h00) begin
            n_fails++;
            $display("FAIL areset_hold: got sum_q=%h cout_q=%b ovf_q=%b, want 00 0 0", sum_q, cout_q, ovf_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({sum_q, cout_q, ovf_q} !== {6'h20, 1'b0, 1'b1}) begin
            n_fails++;
            $display("FAIL areset_release: got sum_q=%h cout_q=%b ovf_q=%b, want 20 0 1", sum_q, cout_q, ovf_q);
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] exp7;
        logic       exp_ovf;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                a = 6'(i);
                b = 6'(j);
                #1;
                exp7    = 7'(i + j);
                exp_ovf = (a[5] == b[5]) && (exp7[5] != a[5]);
                n_checks++;
                if ({cout, sum} !== exp7) begin
                    n_fails++;
                    $display("FAIL exh_sum: a=%h b=%h got {cout,sum}=%h, want %h", a, b, {cout, sum}, exp7);
                end
                n_checks++;
                if (ovf !== exp_ovf) begin
                    n_fails++;
                    $display("FAIL exh_ovf: a=%h b=%h got ovf=%b, want %b", a, b, ovf, exp_ovf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_random();
        test_wrap();
        test_signed_overflow();
        test_pipeline();
        test_async_reset();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_adder_6b
